// File: rtl/mo_mul.sv
// ---------------------------------------------------------------------------
// mo_mul : pipelined modular multiplier over Z_Q for the NTT butterfly.
//
// Default build is a Montgomery multiplier:
//   result = a * b * 2^-DATA_WIDTH mod Q
// Built with MULTYPE_KRED defined, it becomes a K-RED multiplier:
//   result = a * b * Q_K^KRED_L mod Q      (Q = Q_K * 2^m + 1)
//
// One operand pair is accepted every clock with no handshake. The result
// appears MUL_STAGE_CNT cycles later, straight from a register.
//
// Ports
//   clk     in   1           rising-edge clock
//   rst     in   1           synchronous active-high reset, zeroes the pipeline
//   a       in   DATA_WIDTH  operand A, 0 <= a <= Q
//   b       in   DATA_WIDTH  operand B, any value
//   result  out  DATA_WIDTH  fully reduced product, 0 <= result < Q
// ---------------------------------------------------------------------------
module mo_mul #(
  parameter int DATA_WIDTH    = 12,
  parameter int Q             = 3329,
  parameter int MUL_STAGE_CNT = 3,
  parameter int Q_K           = 13,
  parameter int KRED_L        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int TW = 2 * DATA_WIDTH;

`ifdef MULTYPE_KRED
  // Split point m such that Q = Q_K * 2^m + 1.
  function automatic int calc_kred_m();
    int v;
    int m;
    v = (Q - 1) / Q_K;
    m = 0;
    while (v > 1) begin
      v = v >> 1;
      m = m + 1;
    end
    return m;
  endfunction

  localparam int KM = calc_kred_m();
  // Each round shrinks the magnitude by roughly 2^m / Q_K, so the product
  // width plus a few guard bits for sign and Q_K growth never overflows.
  localparam int CW    = TW + 8;
  localparam int MID_W = CW;

  localparam logic signed [CW-1:0] QK_S   = CW'(Q_K);
  localparam logic signed [CW-1:0] Q_S    = CW'(Q);
  localparam logic signed [CW-1:0] MASK_S = CW'((64'd1 << KM) - 64'd1);

  // Q_K*2^m == -1 (mod Q), so Q_K*C == Q_K*C_lo - C_hi (mod Q).
  // C_hi uses an arithmetic shift so the split also holds for negative C.
  function automatic logic signed [CW-1:0] kred_round(input logic signed [CW-1:0] c);
    logic signed [CW-1:0] lo;
    logic signed [CW-1:0] hi;
    lo = c & MASK_S;
    hi = c >>> KM;
    return QK_S * lo - hi;
  endfunction

  // First reduction round (the "reduction multiply" step).
  function automatic logic [MID_W-1:0] mid_f(input logic [TW-1:0] t);
    logic signed [CW-1:0] c;
    c = signed'({{(CW-TW){1'b0}}, t});
    if (KRED_L >= 1) c = kred_round(c);
    return c;
  endfunction

  // Remaining rounds, then fold the signed value into [0, Q).
  function automatic logic [W-1:0] out_f(input logic [MID_W-1:0] mid);
    logic signed [CW-1:0] c;
    logic signed [CW-1:0] r;
    c = signed'(mid);
    for (int i = 1; i < KRED_L; i++) c = kred_round(c);
    r = c % Q_S;
    if (r < 0) r = r + Q_S;
    return r[W-1:0];
  endfunction
`else
  // QINV = -Q^-1 mod 2^W via Newton iteration (each step doubles the
  // number of correct low bits; Q itself is its own inverse mod 8).
  function automatic longint calc_qinv();
    longint inv;
    longint q_l;
    q_l = longint'(Q);
    inv = q_l;
    for (int i = 0; i < 6; i++) inv = inv * (64'sd2 - q_l * inv);
    return (-inv) & ((64'sd1 <<< W) - 64'sd1);
  endfunction

  localparam logic [W-1:0] QINV  = W'(calc_qinv());
  localparam logic [TW-1:0] Q_T  = TW'(Q);
  localparam logic [W:0]   Q_U   = (W+1)'(Q);
  localparam int           MID_W = TW + W;

  // Reduction multiply: m = (T mod R) * QINV mod R, carried alongside T.
  function automatic logic [MID_W-1:0] mid_f(input logic [TW-1:0] t);
    logic [TW-1:0] p;
    p = TW'(t[W-1:0]) * TW'(QINV);
    return {t, p[W-1:0]};
  endfunction

  // Add/shift then a single conditional subtract. T + m*Q is exactly
  // divisible by R; one extra bit holds the carry even for out-of-range a.
  function automatic logic [W-1:0] out_f(input logic [MID_W-1:0] mid);
    logic [TW-1:0] t;
    logic [W-1:0]  m;
    logic [TW:0]   s;
    logic [W:0]    u;
    t = mid[MID_W-1:W];
    m = mid[W-1:0];
    s = {1'b0, t} + {1'b0, TW'(m) * Q_T};
    u = s[TW:W];
    if (u >= Q_U) u = u - Q_U;
    return u[W-1:0];
  endfunction
`endif

  logic [TW-1:0] prod;
  logic [W-1:0]  res_in;

  assign prod = TW'(a) * TW'(b);

  // Register placement: 1 stage -> output only; 2 -> product + output;
  // 3+ -> product, reduction multiply, output, and the rest pure delay.
  generate
    if (MUL_STAGE_CNT == 1) begin : g_s1
      assign res_in = out_f(mid_f(prod));
    end else if (MUL_STAGE_CNT == 2) begin : g_s2
      logic [TW-1:0] t_q;
      always_ff @(posedge clk) begin
        if (rst) t_q <= '0;
        else     t_q <= prod;
      end
      assign res_in = out_f(mid_f(t_q));
    end else begin : g_s3
      logic [TW-1:0]    t_q;
      logic [MID_W-1:0] mid_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          t_q   <= '0;
          mid_q <= '0;
        end else begin
          t_q   <= prod;
          mid_q <= mid_f(t_q);
        end
      end
      assign res_in = out_f(mid_q);
    end
  endgenerate

  localparam int OUT_D = (MUL_STAGE_CNT >= 3) ? MUL_STAGE_CNT - 2 : 1;

  logic [W-1:0] out_pipe [OUT_D];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OUT_D; i++) out_pipe[i] <= '0;
    end else begin
      out_pipe[0] <= res_in;
      for (int i = 1; i < OUT_D; i++) out_pipe[i] <= out_pipe[i-1];
    end
  end

  assign result = out_pipe[OUT_D-1];

endmodule

// File: tb/tb_mo_mul.sv
// ---------------------------------------------------------------------------
// tb_mo_mul : self-checking bench for mo_mul in its default Montgomery build.
// Expected results come from modular arithmetic on the operands
// (a*b * R^-1 mod Q) combined with the latency/reset rule, using a history
// of every applied input and reset value.
// ---------------------------------------------------------------------------
module tb_mo_mul;

  localparam int W   = 12;
  localparam int Q   = 3329;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;

  mo_mul #(
    .DATA_WIDTH   (W),
    .Q            (Q),
    .MUL_STAGE_CNT(LAT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int exp;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int rinv     = 0;
  int max_seen = 0;
  int min_seen = Q;
  int hist_a[$];
  int hist_b[$];
  bit hist_r[$];
  vec_t vecs[7];

  function automatic int ref_mul(input int x, input int y);
    longint p;
    p = longint'(x) * longint'(y);
    return int'(((p % Q) * longint'(rinv)) % Q);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then check the output against the model:
  // the pair sampled LAT-1 edges ago, or zero if reset was sampled since.
  task automatic step(input int av, input int bv, input bit rv);
    int  n;
    int  lo;
    bit  zero;
    int  exp;
    a   = W'(av);
    b   = W'(bv);
    rst = rv;
    @(posedge clk);
    hist_a.push_back(av);
    hist_b.push_back(bv);
    hist_r.push_back(rv);
    @(negedge clk);
    n    = hist_r.size() - 1;
    lo   = (n >= LAT - 1) ? n - (LAT - 1) : 0;
    zero = 1'b0;
    for (int k = lo; k <= n; k++) if (hist_r[k]) zero = 1'b1;
    if (zero) begin
      check("pipe_reset", int'(result), 0);
    end else if (n >= LAT - 1) begin
      exp = ref_mul(hist_a[lo], hist_b[lo]);
      check("pipe", int'(result), exp);
      if (hist_a[lo] <= Q) begin
        if (int'(result) > max_seen) max_seen = int'(result);
        if (int'(result) < min_seen) min_seen = int'(result);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    a   = '0;
    b   = '0;

    for (int x = 1; x < Q; x++) if (((4096 * x) % Q) == 1) rinv = x;

    vecs[0] = '{a: 1,    b: 1,    exp: 2704};
    vecs[1] = '{a: 1234, b: 767,  exp: 1234};
    vecs[2] = '{a: 0,    b: 4095, exp: 0};
    vecs[3] = '{a: 3329, b: 17,   exp: 0};
    vecs[4] = '{a: 3328, b: 4095, exp: 2703};
    vecs[5] = '{a: 3329, b: 4095, exp: 0};
    vecs[6] = '{a: 2,    b: 767,  exp: 2};

    // Reset held two cycles with non-zero operands present.
    for (int i = 0; i < 2; i++) begin
      step(5, 5, 1'b1);
      check("reset_hold", int'(result), 0);
    end
    for (int i = 0; i < LAT - 1; i++) begin
      step(5, 5, 1'b0);
      check("reset_tail", int'(result), 0);
    end
    step(5, 5, 1'b0);
    check("first_after_reset", int'(result), (25 * 2704) % Q);

    // Directed vectors, each followed by idle cycles so it emerges alone.
    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].b, 1'b0);
      for (int k = 0; k < LAT - 1; k++) step(0, 0, 1'b0);
      check($sformatf("vec%0d", i), int'(result), vecs[i].exp);
    end

    // Back-to-back boundary pairs: outputs must stay aligned by LAT.
    step(1, 1, 1'b0);
    step(3328, 4095, 1'b0);
    step(3329, 17, 1'b0);
    check("b2b_0", int'(result), 2704);
    step(1234, 767, 1'b0);
    check("b2b_1", int'(result), 2703);
    step(0, 0, 1'b0);
    check("b2b_2", int'(result), 0);
    step(0, 0, 1'b0);
    check("b2b_3", int'(result), 1234);

    // Full a sweep, one pair per cycle, with a one-cycle reset mid-stream.
    for (int av = 0; av <= Q; av++) begin
      step(av, (av * 37 + 11) % 4096, (av == 1800));
      if (av == 1800) check("mid_reset", int'(result), 0);
    end

    // Randomized operands biased towards the boundaries.
    for (int i = 0; i < 3000; i++) begin
      int av;
      int bv;
      av = int'($urandom_range(0, Q));
      bv = int'($urandom_range(0, 4095));
      if ($urandom_range(0, 7) == 0) av = ($urandom_range(0, 1) != 0) ? Q : Q - 1;
      if ($urandom_range(0, 7) == 0) bv = 4095;
      step(av, bv, ($urandom_range(0, 499) == 0));
    end

    for (int k = 0; k < LAT; k++) step(0, 0, 1'b0);

    check("max_in_range", int'(max_seen <= Q - 1), 1);
    check("min_in_range", int'(min_seen >= 0 && min_seen < Q), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
